// File: rtl/gpr_pkg.sv
// Shared constants for the multi-ported general-purpose register file.
package gpr_pkg;

  localparam int unsigned GPR_DATA_LEN = 64;
  localparam int unsigned GPR_RF_SIZE  = 5;
  localparam int unsigned GPR_NUM_RD   = 2;
  localparam int unsigned GPR_NUM_WR   = 2;
  localparam bit          GPR_BYPASS   = 1'b1;

  // Architectural zero register address
  localparam int unsigned GPR_X0_ADDR  = 0;

endpackage

// File: rtl/gpr_rd_port.sv
// One read port: optional same-cycle write forwarding plus the x0 zero-mux.
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_LEN = GPR_DATA_LEN,
  parameter int unsigned RF_SIZE  = GPR_RF_SIZE,
  parameter int unsigned NUM_WR   = GPR_NUM_WR,
  parameter bit          BYPASS   = GPR_BYPASS
) (
  input  logic [RF_SIZE-1:0]         rs_addr_i,
  input  logic [DATA_LEN-1:0]        arr_data_i,
  input  logic                       pend_cur_i,
  input  logic                       pend_nxt_i,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*RF_SIZE-1:0]  wr_addr_i,
  input  logic [NUM_WR*DATA_LEN-1:0] wr_data_i,
  output logic [DATA_LEN-1:0]        rd_data_c,
  output logic                       rd_busy_c
);

  localparam logic [RF_SIZE-1:0] X0 = RF_SIZE'(GPR_X0_ADDR);

  // Select array or forwarded data; later write ports override earlier ones
  always_comb begin
    rd_data_c = arr_data_i;
    rd_busy_c = pend_cur_i;
    if (BYPASS) begin
      rd_busy_c = pend_nxt_i;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] && (wr_addr_i[j*RF_SIZE +: RF_SIZE] == rs_addr_i)) begin
          rd_data_c = wr_data_i[j*DATA_LEN +: DATA_LEN];
        end
      end
    end
    if (rs_addr_i == X0) begin
      rd_data_c = '0;
      rd_busy_c = 1'b0;
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-ported register file with a pending-write scoreboard and registered reads.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_LEN = GPR_DATA_LEN,
  parameter int unsigned RF_SIZE  = GPR_RF_SIZE,
  parameter int unsigned NUM_RD   = GPR_NUM_RD,
  parameter int unsigned NUM_WR   = GPR_NUM_WR,
  parameter bit          BYPASS   = GPR_BYPASS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*RF_SIZE-1:0]  rs_addr_i,
  output logic [NUM_RD*DATA_LEN-1:0] rs_data_o,
  output logic [NUM_RD-1:0]          rs_busy_o,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*RF_SIZE-1:0]  wr_addr_i,
  input  logic [NUM_WR*DATA_LEN-1:0] wr_data_i,
  input  logic                       claim_en_i,
  input  logic [RF_SIZE-1:0]         claim_addr_i,
  output logic [(2**RF_SIZE)-1:0]    pending_o
);

  localparam int unsigned        NUM_REGS = 2**RF_SIZE;
  localparam logic [RF_SIZE-1:0] X0       = RF_SIZE'(GPR_X0_ADDR);

  logic [DATA_LEN-1:0] regs_q [NUM_REGS];
  logic [DATA_LEN-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  logic [DATA_LEN-1:0] arr_rd    [NUM_RD];
  logic [DATA_LEN-1:0] port_data [NUM_RD];
  logic [NUM_RD-1:0]   cur_bit;
  logic [NUM_RD-1:0]   nxt_bit;
  logic [NUM_RD-1:0]   port_busy;

  logic [NUM_RD*DATA_LEN-1:0] rs_data_d;
  logic [NUM_RD-1:0]          rs_busy_d;

  // Next array and scoreboard: writes commit and clear, a claim then sets
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j*RF_SIZE +: RF_SIZE] != X0)) begin
        regs_d[wr_addr_i[j*RF_SIZE +: RF_SIZE]] = wr_data_i[j*DATA_LEN +: DATA_LEN];
        pend_d[wr_addr_i[j*RF_SIZE +: RF_SIZE]] = 1'b0;
      end
    end
    if (claim_en_i && (claim_addr_i != X0)) begin
      pend_d[claim_addr_i] = 1'b1;
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  // Per-port array lookup of data and scoreboard bits
  always_comb begin
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      arr_rd[k]  = regs_q[rs_addr_i[k*RF_SIZE +: RF_SIZE]];
      cur_bit[k] = pend_q[rs_addr_i[k*RF_SIZE +: RF_SIZE]];
      nxt_bit[k] = pend_d[rs_addr_i[k*RF_SIZE +: RF_SIZE]];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    gpr_rd_port #(
      .DATA_LEN (DATA_LEN),
      .RF_SIZE  (RF_SIZE),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .rs_addr_i  (rs_addr_i[k*RF_SIZE +: RF_SIZE]),
      .arr_data_i (arr_rd[k]),
      .pend_cur_i (cur_bit[k]),
      .pend_nxt_i (nxt_bit[k]),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .rd_data_c  (port_data[k]),
      .rd_busy_c  (port_busy[k])
    );
  end

  // Pack per-port results into the flat output buses
  always_comb begin
    rs_data_d = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rs_data_d[k*DATA_LEN +: DATA_LEN] = port_data[k];
    end
    rs_busy_d = port_busy;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q    <= '0;
      rs_data_o <= '0;
      rs_busy_o <= '0;
    end else begin
      regs_q    <= regs_d;
      pend_q    <= pend_d;
      rs_data_o <= rs_data_d;
      rs_busy_o <= rs_busy_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: bypass and non-bypass instances share stimulus against one model.
module tb_gpr_mp;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   rs_addr    = '0;
  logic [1:0]   wr_en      = '0;
  logic [9:0]   wr_addr    = '0;
  logic [127:0] wr_data    = '0;
  logic         claim_en   = 1'b0;
  logic [4:0]   claim_addr = '0;

  logic [127:0] data_b, data_n;
  logic [1:0]   busy_b, busy_n;
  logic [31:0]  pend_b, pend_n;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpr_mp #(.DATA_LEN(64), .RF_SIZE(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr), .rs_data_o(data_b), .rs_busy_o(busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .claim_en_i(claim_en), .claim_addr_i(claim_addr), .pending_o(pend_b));

  gpr_mp #(.DATA_LEN(64), .RF_SIZE(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .rs_addr_i(rs_addr), .rs_data_o(data_n), .rs_busy_o(busy_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .claim_en_i(claim_en), .claim_addr_i(claim_addr), .pending_o(pend_n));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: register contents, pending set, expected read results
  logic [63:0] m_regs [32];
  logic [63:0] n_regs [32];
  logic [31:0] m_pend = '0;
  logic [31:0] n_pend;
  logic [63:0] e_bd [2] = '{64'd0, 64'd0};
  logic [63:0] e_nd [2] = '{64'd0, 64'd0};
  logic [1:0]  e_bb = '0;
  logic [1:0]  e_nb = '0;
  int unsigned m_a;

  initial for (int i = 0; i < 32; i++) m_regs[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend = '0;
      e_bd[0] = '0; e_bd[1] = '0; e_nd[0] = '0; e_nd[1] = '0;
      e_bb = '0; e_nb = '0;
    end else begin
      n_regs = m_regs;
      n_pend = m_pend;
      for (int j = 0; j < 2; j++) begin
        m_a = 32'(wr_addr[j*5 +: 5]);
        if (wr_en[j] && m_a != 0) begin
          n_regs[m_a] = wr_data[j*64 +: 64];
          n_pend[m_a] = 1'b0;
        end
      end
      if (claim_en && claim_addr != 5'd0) n_pend[claim_addr] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_a = 32'(rs_addr[k*5 +: 5]);
        e_bd[k] = (m_a == 0) ? 64'd0 : n_regs[m_a];
        e_nd[k] = (m_a == 0) ? 64'd0 : m_regs[m_a];
        e_bb[k] = (m_a == 0) ? 1'b0 : n_pend[m_a];
        e_nb[k] = (m_a == 0) ? 1'b0 : m_pend[m_a];
      end
      m_regs = n_regs;
      m_pend = n_pend;
    end
  end

  // Every falling edge: both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("byp_data", data_b[k*64 +: 64], e_bd[k]);
      chk("nob_data", data_n[k*64 +: 64], e_nd[k]);
      chk("byp_busy", 64'(busy_b[k]), 64'(e_bb[k]));
      chk("nob_busy", 64'(busy_n[k]), 64'(e_nb[k]));
    end
    chk("byp_pend", 64'(pend_b), 64'(m_pend));
    chk("nob_pend", 64'(pend_n), 64'(m_pend));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int j, input logic en, input logic [4:0] a, input logic [63:0] d);
    wr_en[j]           = en;
    wr_addr[j*5 +: 5]  = a;
    wr_data[j*64 +: 64] = d;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr = {a1, a0};
  endtask

  task automatic idle();
    wr_en    = '0;
    claim_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_data", data_b[63:0], 64'd0);
    rst_n = 1'b1;

    // Fresh reset: every register reads zero and idle
    for (int a = 1; a < 32; a++) begin
      set_rd(5'(a), 5'(32 - a));
      tick();
      chk("init_d0", data_b[63:0], 64'd0);
      chk("init_b1", 64'(busy_b[1]), 64'd0);
    end

    // Same-cycle write and read of x5
    set_wr(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
    set_rd(5'd5, 5'd0);
    tick();
    idle();
    chk("x5_byp", data_b[63:0], 64'hDEAD_BEEF);
    chk("x5_nob0", data_n[63:0], 64'd0);
    tick();
    chk("x5_nob1", data_n[63:0], 64'hDEAD_BEEF);

    // Two ports write x7; port 1 wins
    set_wr(0, 1'b1, 5'd7, 64'h11);
    set_wr(1, 1'b1, 5'd7, 64'h22);
    set_rd(5'd0, 5'd7);
    tick();
    chk("x7_byp", data_b[127:64], 64'h22);
    idle();
    tick();
    chk("x7_nob", data_n[127:64], 64'h22);

    // x0 is immune to writes and claims
    set_wr(0, 1'b1, 5'd0, 64'hFFFF);
    claim_en = 1'b1; claim_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    tick();
    idle();
    tick();
    chk("x0_data", data_b[63:0], 64'd0);
    chk("x0_busy", 64'(busy_b[0]), 64'd0);
    chk("x0_pend", 64'(pend_b[0]), 64'd0);

    // Claim x9, hold the read, then write clears, then claim+write keeps it set
    claim_en = 1'b1; claim_addr = 5'd9;
    set_rd(5'd9, 5'd9);
    tick();
    idle();
    chk("x9_busy_a", 64'(busy_b[0]), 64'd1);
    chk("x9_nob_a", 64'(busy_n[0]), 64'd0);
    tick();
    chk("x9_busy_b", 64'(busy_b[0]), 64'd1);
    tick();
    chk("x9_busy_c", 64'(busy_b[0]), 64'd1);
    set_wr(0, 1'b1, 5'd9, 64'h33);
    tick();
    idle();
    chk("x9_wr_busy", 64'(busy_b[0]), 64'd0);
    chk("x9_wr_data", data_b[63:0], 64'h33);
    chk("x9_nob_busy", 64'(busy_n[0]), 64'd1);
    set_wr(1, 1'b1, 5'd9, 64'h44);
    claim_en = 1'b1; claim_addr = 5'd9;
    tick();
    idle();
    chk("x9_cw_busy", 64'(busy_b[1]), 64'd1);
    chk("x9_cw_data", data_b[127:64], 64'h44);
    chk("x9_cw_pend", 64'(pend_b[9]), 64'd1);

    // Mixed traffic over a spread of addresses, reads chase the writes
    for (int i = 0; i < 16; i++) begin
      set_wr(0, 1'(i % 3 != 2), 5'((i * 3) % 32), 64'h1000 + 64'(i));
      set_wr(1, 1'(i % 4 != 3), 5'((i * 5 + 1) % 32), {32'hA5A5_0000, 32'(i)});
      claim_en   = 1'(i % 2);
      claim_addr = 5'((i * 7) % 32);
      set_rd(5'(((i + 15) * 3) % 32), 5'((i * 5 + 1) % 32));
      tick();
    end
    idle();
    set_rd(5'd1, 5'd3);
    tick();
    tick();

    // Asynchronous reset pulse between edges
    chk("pre_rst_pend", 64'(pend_b != 32'd0), 64'd1);
    set_rd(5'd5, 5'd9);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_data_b", data_b[63:0], 64'd0);
    chk("arst_data_n", data_n[127:64], 64'd0);
    chk("arst_busy", 64'(busy_b), 64'd0);
    chk("arst_pend", 64'(pend_b), 64'd0);
    // Write and claim while reset is held across an edge
    set_wr(0, 1'b1, 5'd3, 64'h77);
    claim_en = 1'b1; claim_addr = 5'd3;
    set_rd(5'd3, 5'd5);
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    chk("post_x3_data", data_b[63:0], 64'd0);
    chk("post_x3_busy", 64'(busy_b[0]), 64'd0);
    chk("post_x5_data", data_b[127:64], 64'd0);
    chk("post_pend", 64'(pend_b), 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_mp.md
GPR_MP -- requirements
Module: gpr_mp

Interface
REQ-001 Parameter DATA_LEN, default 64, SHALL set the register data width in bits.
REQ-002 Parameter RF_SIZE, default 5, SHALL set the address width; the register count is 2**RF_SIZE.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of read ports (1..4).
REQ-004 Parameter NUM_WR, default 2, SHALL set the number of write ports (1..2).
REQ-005 Parameter BYPASS, default 1, SHALL enable (1) or disable (0) same-cycle write-to-read forwarding.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port rs_addr_i, input, NUM_RD*RF_SIZE bits: read addresses, port k in slice k.
REQ-009 Port rs_data_o, output reg, NUM_RD*DATA_LEN bits: registered read data, port k in slice k.
REQ-010 Port rs_busy_o, output reg, NUM_RD bits: registered pending-write flag per read port.
REQ-011 Port wr_en_i, input, NUM_WR bits: per-port write enables.
REQ-012 Port wr_addr_i, input, NUM_WR*RF_SIZE bits: write addresses.
REQ-013 Port wr_data_i, input, NUM_WR*DATA_LEN bits: write data.
REQ-014 Port claim_en_i, input, 1 bit: marks claim_addr_i pending (scoreboard set).
REQ-015 Port claim_addr_i, input, RF_SIZE bits: destination register being claimed.
REQ-016 Port pending_o, output, 2**RF_SIZE bits: current scoreboard vector, with bit 0 always 0.

Function
REQ-017 A write SHALL update the register at the rising edge when wr_en_i[j]=1 and wr_addr_i[j]!=0.
REQ-018 Writes to x0 SHALL be ignored; x0 SHALL always read as 0 and never be pending.
REQ-019 If two write ports target the same address in one cycle, the higher-index port SHALL win.
REQ-020 Read latency SHALL be 1 cycle: rs_data_o[k] at edge N+1 reflects rs_addr_i[k] sampled at edge N.
REQ-021 A read of x0 SHALL return 0 on rs_data_o and 0 on rs_busy_o.
REQ-022 With BYPASS=1, a read matching an enabled same-cycle write address SHALL return that write's data, using the winner per REQ-019.
REQ-023 With BYPASS=0, a read SHALL return the pre-write array contents.
REQ-024 claim_en_i=1 with claim_addr_i!=0 SHALL set pending[claim_addr_i] at the edge.
REQ-025 Any committed write SHALL clear pending[wr_addr] at the edge.
REQ-026 If a claim and a write hit the same address in the same cycle, the claim SHALL win and the bit ends set.
REQ-027 With BYPASS=1, rs_busy_o SHALL equal the next-state pending bit of the addressed register.
REQ-028 With BYPASS=0, rs_busy_o SHALL equal the current-state pending bit.
REQ-029 All read ports SHALL operate independently; multiple ports may read the same address.

Reset
REQ-030 While rst_n=0, all registers, all pending bits, rs_data_o and rs_busy_o SHALL be 0 immediately, without waiting for a clock edge.
REQ-031 Writes and claims presented during reset SHALL be discarded.
REQ-032 The first edge after rst_n deasserts SHALL behave as a normal cycle.

Structure
REQ-033 Package gpr_pkg SHALL hold the default parameter constants and the x0 address constant.
REQ-034 The per-port bypass and zero-mux logic SHALL be one sub-module, gpr_rd_port, instantiated NUM_RD times by generate.
REQ-035 The array write, the scoreboard and the output registers SHALL stay in gpr_mp.

Verification
REQ-036 Reset then read x1..x31 -> rs_data_o=0 and rs_busy_o=0 on all ports.
REQ-037 Write x5=0xDEAD_BEEF on port 0 and read x5 in the same cycle: BYPASS=1 -> next cycle 0xDEADBEEF; BYPASS=0 -> 0, then 0xDEADBEEF one cycle later.
REQ-038 Same-cycle writes of x7 (port0=0x11, port1=0x22) -> x7 reads 0x22.
REQ-039 Write x0=0xFFFF and claim x0, then read x0 -> data 0, busy 0, pending_o[0]=0.
REQ-040 Claim x9, then hold x9 on a read port for 3 cycles, then write x9=0x33 -> busy 1,1,1, then 0 (BYPASS=1) with data 0x33; a same-cycle claim and write of x9 leaves busy 1.
REQ-041 Pulse rst_n low between edges after writes and claims -> outputs, array and pending_o go to 0 asynchronously.
